// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus definitions: transaction owner tags, access sizes and
// the arbiter FSM encoding.
package cpu_bus_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/sram_like_arbiter_owner_fifo.sv
// In-order FIFO of transaction owners; no push-to-pop bypass, async reset.
module owner_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 1,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_like_arbiter.sv
// Shares one sram-like port between the instruction and data masters;
// grants lock until addr_ok and responses are routed in order via owner_fifo.
module sram_like_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              err_orphan
);

    localparam int unsigned CW = $clog2(MAX_OUT + 1);

    arb_state_t    state, state_nxt;
    logic          lock_owner, lock_owner_nxt;
    logic          sel_owner;
    logic          sel_is_data;
    logic          sel_req;
    logic          addr_hs;
    logic          resp_pop;
    logic          head_owner;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // While locked the owner keeps the port even if the other master asks.
    assign sel_owner   = (state == ARB_LOCKED) ? lock_owner
                                               : (data_req ? OWNER_DATA : OWNER_INST);
    assign sel_is_data = (sel_owner == OWNER_DATA);
    assign sel_req     = sel_is_data ? data_req : inst_req;

    assign mem_req   = ~reset & ~fifo_full & sel_req;
    assign mem_wr    = sel_is_data ? data_wr    : inst_wr;
    assign mem_size  = sel_is_data ? data_size  : inst_size;
    assign mem_wstrb = sel_is_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = sel_is_data ? data_addr  : inst_addr;
    assign mem_wdata = sel_is_data ? data_wdata : inst_wdata;

    assign addr_hs      = mem_req & mem_addr_ok;
    assign inst_addr_ok = addr_hs & ~sel_is_data;
    assign data_addr_ok = addr_hs &  sel_is_data;

    assign resp_pop     = ~reset & mem_data_ok & (|fifo_count);
    assign inst_data_ok = resp_pop & (head_owner == OWNER_INST);
    assign data_data_ok = resp_pop & (head_owner == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    owner_fifo #(
        .DEPTH (MAX_OUT),
        .WIDTH (1)
    ) u_owner_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (addr_hs),
        .pop   (resp_pop),
        .din   (sel_owner),
        .dout  (head_owner),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_nxt      = state;
        lock_owner_nxt = lock_owner;
        case (state)
            ARB_IDLE: begin
                if (mem_req && !mem_addr_ok) begin
                    state_nxt      = ARB_LOCKED;
                    lock_owner_nxt = sel_owner;
                end
            end
            ARB_LOCKED: begin
                // A dropped req is a protocol violation; release without a handshake.
                if (!sel_req || addr_hs) begin
                    state_nxt = ARB_IDLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ARB_IDLE;
            lock_owner <= OWNER_INST;
            err_orphan <= 1'b0;
        end else begin
            state      <= state_nxt;
            lock_owner <= lock_owner_nxt;
            if (mem_data_ok && fifo_empty) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule
